// File: rtl/hs_cdc_gray_syncer_pkg.sv
// Shared Gray-code helpers and synchroniser depth limits for the hs_cdc block family.
package hs_cdc_pkg;

  localparam int unsigned SYNC_STAGE_MIN = 2;
  localparam int unsigned SYNC_STAGE_MAX = 32;
  localparam int unsigned MAX_WIDTH      = 32;

  // Narrower buses are zero-extended; leading zeros leave the XOR prefix unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int unsigned i = MAX_WIDTH-1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hs_cdc_syncer_sr.sv
// Single-bit SYNC_STAGE-deep synchroniser chain with synchronous active-low reset.
module hs_cdc_syncer_sr #(
  parameter int unsigned SYNC_STAGE = 2,
  parameter logic        RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic sresetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGE-1:0] sr;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      sr <= {SYNC_STAGE{RESET_VAL}};
    end else begin
      sr <= {sr[SYNC_STAGE-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGE-1];

endmodule

// File: rtl/hs_cdc_gray_syncer.sv
// Destination-domain Gray bus synchroniser with binary conversion, step delta and
// illegal-transition detection.
module hs_cdc_gray_syncer
  import hs_cdc_pkg::*;
#(
  parameter int unsigned      SYNC_STAGE = 2,
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_GRAY = '0
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] delta,
  output logic             chg,
  output logic             err_pulse,
  output logic             err_sticky
);

  if ((SYNC_STAGE < SYNC_STAGE_MIN) || (SYNC_STAGE > SYNC_STAGE_MAX)) begin : g_bad_stage
    $error("hs_cdc_gray_syncer: SYNC_STAGE out of range 2..32");
  end
  if ((WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("hs_cdc_gray_syncer: WIDTH out of range 2..32");
  end

  localparam logic [WIDTH-1:0] RESET_BIN = WIDTH'(gray2bin(MAX_WIDTH'(RESET_GRAY)));

  logic [WIDTH-1:0] g_new;
  logic [WIDTH-1:0] new_bin;
  logic             err_set;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    hs_cdc_syncer_sr #(
      .SYNC_STAGE (SYNC_STAGE),
      .RESET_VAL  (RESET_GRAY[i])
    ) u_sync (
      .clk     (clk),
      .sresetn (sresetn),
      .d       (gray_in[i]),
      .q       (g_new[i])
    );
  end

  // bin_out always equals gray2bin(gray_out), so it stands in for the old binary value.
  always_comb begin
    new_bin = WIDTH'(gray2bin(MAX_WIDTH'(g_new)));
    err_set = popcount(MAX_WIDTH'(g_new ^ gray_out)) > 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      gray_out   <= RESET_GRAY;
      bin_out    <= RESET_BIN;
      delta      <= '0;
      chg        <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      gray_out   <= g_new;
      bin_out    <= new_bin;
      delta      <= new_bin - bin_out;
      chg        <= (g_new != gray_out);
      err_pulse  <= err_set;
      err_sticky <= err_set | (err_sticky & ~err_clr);
    end
  end

endmodule

// File: tb/tb_hs_cdc_gray_syncer.sv
// Directed bench for hs_cdc_gray_syncer (SYNC_STAGE=3, WIDTH=8, RESET_GRAY=8'h0C).
module tb_hs_cdc_gray_syncer;

  logic       clk = 1'b0;
  logic       sresetn = 1'b0;
  logic [7:0] gray_in = 8'h0C;
  logic       err_clr = 1'b0;
  logic [7:0] gray_out, bin_out, delta;
  logic       chg, err_pulse, err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  hs_cdc_gray_syncer #(
    .SYNC_STAGE (3),
    .WIDTH      (8),
    .RESET_GRAY (8'h0C)
  ) dut (
    .clk        (clk),
    .sresetn    (sresetn),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .gray_out   (gray_out),
    .bin_out    (bin_out),
    .delta      (delta),
    .chg        (chg),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    gray_in = 8'h0C;
    tick(3);
    n_checks++; if (gray_out !== 8'h0C) begin n_fail++; $display("FAIL reset_gray got %h exp %h", gray_out, 8'h0C); end
    n_checks++; if (bin_out !== 8'h08) begin n_fail++; $display("FAIL reset_bin got %h exp %h", bin_out, 8'h08); end
    n_checks++; if (delta !== 8'h00) begin n_fail++; $display("FAIL reset_delta got %h exp %h", delta, 8'h00); end
    n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg got %b exp 0", chg); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b exp 0", err_pulse); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got %b exp 0", err_sticky); end
    sresetn = 1'b1;
    tick(2);
    n_checks++; if (gray_out !== 8'h0C) begin n_fail++; $display("FAIL reset_hold got %h exp %h", gray_out, 8'h0C); end
  endtask

  task automatic test_latency();
    gray_in = 8'h07;   // gray of 5
    tick(6);
    clear_err();
    n_checks++; if (bin_out !== 8'd5) begin n_fail++; $display("FAIL lat_pre_bin got %0d exp 5", bin_out); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL lat_clr_sticky got %b exp 0", err_sticky); end
    gray_in = 8'h05;   // gray of 6
    tick(3);
    n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL lat_early_chg got %b exp 0", chg); end
    n_checks++; if (gray_out !== 8'h07) begin n_fail++; $display("FAIL lat_early_gray got %h exp %h", gray_out, 8'h07); end
    tick();
    n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL lat_chg got %b exp 1", chg); end
    n_checks++; if (bin_out !== 8'd6) begin n_fail++; $display("FAIL lat_bin got %0d exp 6", bin_out); end
    n_checks++; if (delta !== 8'd1) begin n_fail++; $display("FAIL lat_delta got %0d exp 1", delta); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL lat_err got %b exp 0", err_pulse); end
    tick();
    n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL lat_chg_drop got %b exp 0", chg); end
    n_checks++; if (delta !== 8'd0) begin n_fail++; $display("FAIL lat_delta_drop got %0d exp 0", delta); end
  endtask

  task automatic test_wrap();
    gray_in = 8'h80;   // gray of 255
    tick(6);
    clear_err();
    n_checks++; if (bin_out !== 8'hFF) begin n_fail++; $display("FAIL wrap_pre_bin got %h exp ff", bin_out); end
    gray_in = 8'h00;
    tick(4);
    n_checks++; if (bin_out !== 8'h00) begin n_fail++; $display("FAIL wrap_bin got %h exp 00", bin_out); end
    n_checks++; if (delta !== 8'd1) begin n_fail++; $display("FAIL wrap_delta got %0d exp 1", delta); end
    n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL wrap_chg got %b exp 1", chg); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b exp 0", err_pulse); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL wrap_sticky got %b exp 0", err_sticky); end
  endtask

  task automatic test_illegal();
    tick();
    gray_in = 8'h03;   // two bits flip from 8'h00
    tick(4);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got %b exp 1", err_pulse); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b exp 1", err_sticky); end
    n_checks++; if (delta !== 8'd2) begin n_fail++; $display("FAIL ill_delta got %0d exp 2", delta); end
    tick();
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL ill_pulse_drop got %b exp 0", err_pulse); end
    tick(3);
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_sticky_hold got %b exp 1", err_sticky); end
    clear_err();
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL ill_clear got %b exp 0", err_sticky); end
    tick();
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL ill_clear_hold got %b exp 0", err_sticky); end
  endtask

  task automatic test_set_wins();
    gray_in = 8'h00;   // two bits flip from 8'h03
    tick(3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sw_pulse got %b exp 1", err_pulse); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sw_sticky got %b exp 1", err_sticky); end
    tick();
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sw_sticky_hold got %b exp 1", err_sticky); end
    clear_err();
  endtask

  task automatic test_midrun_reset();
    logic [7:0] k8;
    for (int k = 1; k <= 20; k++) begin
      k8 = 8'(k);
      gray_in = k8 ^ (k8 >> 1);
      tick(4);
      n_checks++; if (bin_out !== k8 || delta !== 8'd1 || chg !== 1'b1 || err_pulse !== 1'b0) begin
        n_fail++; $display("FAIL count_%0d got bin=%0d delta=%0d chg=%b err=%b exp bin=%0d delta=1 chg=1 err=0", k, bin_out, delta, chg, err_pulse, k);
      end
    end
    gray_in = 8'h1F;   // gray of 21, still in the chain when reset hits
    tick(2);
    sresetn = 1'b0;
    tick();
    sresetn = 1'b1;
    n_checks++; if (gray_out !== 8'h0C || bin_out !== 8'h08 || delta !== 8'h00 || chg !== 1'b0 || err_pulse !== 1'b0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got gray=%h bin=%h delta=%h chg=%b ep=%b es=%b exp 0c/08/00/0/0/0", gray_out, bin_out, delta, chg, err_pulse, err_sticky);
    end
    tick(3);
    n_checks++; if (chg !== 1'b0 || gray_out !== 8'h0C) begin n_fail++; $display("FAIL mid_flush got gray=%h chg=%b exp 0c/0", gray_out, chg); end
    tick();
    n_checks++; if (bin_out !== 8'd21) begin n_fail++; $display("FAIL mid_resume_bin got %0d exp 21", bin_out); end
    n_checks++; if (delta !== 8'd13) begin n_fail++; $display("FAIL mid_resume_delta got %0d exp 13", delta); end
    n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL mid_resume_chg got %b exp 1", chg); end
    for (int k = 22; k <= 40; k++) begin
      k8 = 8'(k);
      gray_in = k8 ^ (k8 >> 1);
      if (k == 22) begin
        clear_err();
        tick(3);
      end else begin
        tick(4);
      end
      n_checks++; if (bin_out !== k8 || delta !== 8'd1 || chg !== 1'b1 || err_pulse !== 1'b0) begin
        n_fail++; $display("FAIL count_%0d got bin=%0d delta=%0d chg=%b err=%b exp bin=%0d delta=1 chg=1 err=0", k, bin_out, delta, chg, err_pulse, k);
      end
    end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_sticky_end got %b exp 0", err_sticky); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_illegal();
    test_set_wins();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_cdc_gray_syncer.md
Name: hs_cdc_gray_syncer

Overview:
Destination-domain synchroniser for Gray-coded counters and pointers crossing from an asynchronous source, such as async FIFO pointers or free-running event counters.
- Samples the Gray bus through a SYNC_STAGE-deep flop chain per bit.
- Registers the result, converts it to binary and reports the increment since the previous sample.
- Flags illegal multi-bit transitions, which indicate a non-Gray source or a source stepping faster than this clock can sample.

Parameters:
SYNC_STAGE, 2, synchroniser depth per bit (range 2-32).
WIDTH, 8, Gray bus width (range 2-32).
RESET_GRAY, 0, Gray value loaded into every chain stage and the output register on reset (WIDTH bits).

Ports:
clk  input  1  destination clock; the only clock of the block.
sresetn  input  1  synchronous, active-low reset, sampled on rising clk.
gray_in  input  WIDTH  asynchronous Gray-coded source value.
err_clr  input  1  clears the sticky error flag (synchronous to clk).
gray_out  output  WIDTH  synchronised, registered Gray value.
bin_out  output  WIDTH  binary equivalent of gray_out.
delta  output  WIDTH  (bin_out - previous bin_out) mod 2^WIDTH, valid in the same cycle as bin_out.
chg  output  1  one-cycle pulse when gray_out differs from its previous value.
err_pulse  output  1  one-cycle pulse on an illegal transition (more than one bit changed).
err_sticky  output  1  latched error, held until err_clr.

Behaviour:
- Reset applies at the clk edge when sresetn=0. It sets:
  - all sync stages and gray_out to RESET_GRAY;
  - bin_out to gray2bin(RESET_GRAY);
  - delta=0, chg=0, err_pulse=0, err_sticky=0.
- Reset mid-operation discards all in-flight samples. The first post-reset sample is compared against RESET_GRAY.
- Pipeline: gray_in -> sync[0] ... sync[SYNC_STAGE-1] -> gray_out register.
- Latency: a stable gray_in change appears on gray_out, bin_out, delta and chg exactly SYNC_STAGE+1 clk edges later. This is ±1 cycle due to metastability resolution on the first stage.
- Let g_new = sync[SYNC_STAGE-1] and g_old = gray_out (current register value). Each cycle:
  - gray_out <= g_new;
  - bin_out <= gray2bin(g_new);
  - delta <= gray2bin(g_new) - gray2bin(g_old), truncated to WIDTH (modulo wrap);
  - chg <= (g_new != g_old);
  - err_pulse <= (popcount(g_new ^ g_old) > 1).
- Wrap-around: a binary transition from 2^WIDTH-1 to 0 is a legal single-bit Gray step. It gives delta=1, chg=1, err_pulse=0.
- delta is computed even on illegal transitions, but is not meaningful when err_pulse=1.
- err_sticky:
  - set when err_pulse is being set;
  - cleared by err_clr=1;
  - if set and clear occur in the same cycle, set wins;
  - err_clr while no error is present has no effect.
- No handshake. Outputs update every cycle, and chg is the only change qualifier.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Package hs_cdc_pkg holds:
  - function gray2bin (parameterised via a WIDTH-sized logic vector, XOR-prefix from the MSB);
  - function bin2gray (for the bench and sibling blocks);
  - function popcount;
  - localparam limits SYNC_STAGE_MIN=2 and SYNC_STAGE_MAX=32.
- One sub-module: hs_cdc_syncer_sr, a single-bit SYNC_STAGE-deep chain with synchronous active-low reset and a per-bit reset value. It is instantiated WIDTH times in a generate loop.
- Compare, convert and error logic stay in the top module.
- Elaboration assertions check the SYNC_STAGE and WIDTH ranges.

Test Plan:
- Reset: WIDTH=8, RESET_GRAY=8'h0C, hold sresetn=0 for 3 cycles -> gray_out=8'h0C, bin_out=8'h08, delta=0, chg=0, err_sticky=0.
- Latency: SYNC_STAGE=3, step gray_in from bin2gray(5) to bin2gray(6) with stable inputs (no X injection) -> chg=1 exactly 4 edges after the change, bin_out=6, delta=1, then chg=0 the next cycle.
- Wrap: step gray_in from bin2gray(255) (8'h80) to 8'h00 -> bin_out=0, delta=1, chg=1, err_pulse=0.
- Illegal jump: step gray_in from 8'h00 to 8'h03 -> err_pulse=1 for one cycle, err_sticky=1 and held. Then err_clr=1 for one cycle -> err_sticky=0.
- Set-wins: assert err_clr in the same cycle an illegal transition reaches the compare stage -> err_sticky remains 1.
- Mid-run reset: count gray_in through 0..40 at 1/4 the clk rate, then pulse sresetn=0 for one cycle mid-run -> all outputs return to reset values the next edge. Counting resumes with a delta equal to the bin difference from gray2bin(RESET_GRAY).
